// File: rtl/twf_12_mul.sv
// twf_12_mul: stage-12 twiddle multiply, drives the twiddle ROM index and
// rotates each sample by the returned 2.7-format twiddle (3-cycle latency).
// Ports: clk, rstn (sync, active-low); din_valid/din_sof/din_re/din_im in;
// twf_idx out to ROM, twf_re/twf_im back same cycle; dout_valid/dout_sof/
// dout_re/dout_im out; frame_done pulses with the output of the last index.
// Build option: TWF_MUL_SAT_EN clamps the scaled result instead of wrapping.
module twf_12_mul #(
  parameter int NUM_POINT  = 512,
  parameter int IDX_WIDTH  = $clog2(NUM_POINT),
  parameter int DATA_WIDTH = 16,
  parameter int TWF_WIDTH  = 9,
  parameter int OUT_WIDTH  = DATA_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         din_valid,
  input  logic                         din_sof,
  input  logic signed [DATA_WIDTH-1:0] din_re,
  input  logic signed [DATA_WIDTH-1:0] din_im,
  output logic        [IDX_WIDTH-1:0]  twf_idx,
  input  logic signed [TWF_WIDTH-1:0]  twf_re,
  input  logic signed [TWF_WIDTH-1:0]  twf_im,
  output logic                         dout_valid,
  output logic                         dout_sof,
  output logic signed [OUT_WIDTH-1:0]  dout_re,
  output logic signed [OUT_WIDTH-1:0]  dout_im,
  output logic                         frame_done
);

  localparam int PW = DATA_WIDTH + TWF_WIDTH;
  localparam int SW = PW + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(NUM_POINT - 1);
  localparam logic signed [SW-1:0] RND = SW'(64);

  logic [IDX_WIDTH-1:0] cnt;
  logic                 idx_last;

  logic                         s1_v, s1_sof, s1_last;
  logic signed [DATA_WIDTH-1:0] s1_ar, s1_ai;
  logic signed [TWF_WIDTH-1:0]  s1_br, s1_bi;

  logic                 s2_v, s2_sof, s2_last;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  logic signed [SW-1:0]        sum_re, sum_im;
  logic signed [SW-1:0]        rnd_re, rnd_im;
  logic signed [OUT_WIDTH-1:0] red_re, red_im;

  // SOF forces index 0 even when cnt is about to wrap
  assign twf_idx  = (din_valid && din_sof) ? '0 : cnt;
  assign idx_last = (twf_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (din_valid) begin
      cnt <= idx_last ? '0 : twf_idx + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v    <= 1'b0;
      s1_sof  <= 1'b0;
      s1_last <= 1'b0;
      s2_v    <= 1'b0;
      s2_sof  <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      s1_v    <= din_valid;
      s1_sof  <= din_valid & din_sof;
      s1_last <= din_valid & idx_last;
      s2_v    <= s1_v;
      s2_sof  <= s1_sof;
      s2_last <= s1_last;
    end
  end

  // data path registers carry no reset; only valid qualifies them
  always_ff @(posedge clk) begin
    s1_ar <= din_re;
    s1_ai <= din_im;
    s1_br <= twf_re;
    s1_bi <= twf_im;
    p_rr  <= PW'(s1_ar) * PW'(s1_br);
    p_ii  <= PW'(s1_ai) * PW'(s1_bi);
    p_ri  <= PW'(s1_ar) * PW'(s1_bi);
    p_ir  <= PW'(s1_ai) * PW'(s1_br);
  end

`ifdef TWF_MUL_SAT_EN
  localparam logic signed [SW-1:0] OMAX =
    SW'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] OMIN = ~OMAX;

  function automatic logic signed [OUT_WIDTH-1:0] sat(
    input logic signed [SW-1:0] v
  );
    logic signed [SW-1:0] r;
    unique case (1'b1)
      (v > OMAX): r = OMAX;
      (v < OMIN): r = OMIN;
      default:    r = v;
    endcase
    return r[OUT_WIDTH-1:0];
  endfunction
`endif

  always_comb begin
    sum_re = SW'(p_rr) - SW'(p_ii);
    sum_im = SW'(p_ri) + SW'(p_ir);
    // round half-up, then drop the 7 twiddle fraction bits
    rnd_re = (sum_re + RND) >>> 7;
    rnd_im = (sum_im + RND) >>> 7;
`ifdef TWF_MUL_SAT_EN
    red_re = sat(rnd_re);
    red_im = sat(rnd_im);
`else
    red_re = rnd_re[OUT_WIDTH-1:0];
    red_im = rnd_im[OUT_WIDTH-1:0];
`endif
  end

`ifndef TWF_MUL_SAT_EN
  logic unused_hi;
  assign unused_hi = ^{rnd_re[SW-1:OUT_WIDTH],
                       rnd_im[SW-1:OUT_WIDTH]};
`endif

  // data outputs only move on a valid, so a reset leaves them at 0
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      frame_done <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      dout_valid <= s2_v;
      dout_sof   <= s2_sof;
      frame_done <= s2_v & s2_last;
      if (s2_v) begin
        dout_re <= red_re;
        dout_im <= red_im;
      end
    end
  end

endmodule
